// File: rtl/pc_unit_stall_if.sv
// Fetch-PC control/observe bundle between the
// hazard/branch logic and the PC unit.
interface pc_unit_stall_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [2:0]       pc_src;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic [25:0]      jump_target;
  logic [WIDTH-1:0] jr_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             redirect_pend;

  modport master (
    output stall, pc_src, branch_taken,
    output branch_target, jump_target, jr_target,
    input  pc, pc_plus, redirect_pend
  );

  modport slave (
    input  stall, pc_src, branch_taken,
    input  branch_target, jump_target, jr_target,
    output pc, pc_plus, redirect_pend
  );
endinterface

// File: rtl/pc_unit_stall.sv
// IF-stage program counter with stall, buffered
// redirect and kernel-bit protection.
module pc_unit_stall #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h80000000,
  parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h80000004,
  parameter logic [WIDTH-1:0] XADR_VEC  = 32'h80000008,
  parameter int               STEP      = 4
) (
  input logic            clk,
  input logic            reset,
  pc_unit_stall_if.slave bus
);
  localparam int KB = WIDTH - 1;
  localparam logic [KB-1:0] STEP_L = KB'(STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] buf_q;
  logic             pend_q;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] cand;
  logic             k;
  logic             redir;
  logic             exc;

  assign k   = pc_q[KB];
  assign seq = {k, pc_q[KB-1:0] + STEP_L};

  assign bus.pc            = pc_q;
  assign bus.pc_plus       = seq;
  assign bus.redirect_pend = pend_q;

  assign exc   = bus.pc_src[2];
  assign redir = (bus.pc_src == 3'b010)
               | (bus.pc_src == 3'b011)
               | ((bus.pc_src == 3'b001)
                  & bus.branch_taken);

  // Candidate next PC; user code may never set K
  always_comb begin
    cand = seq;
    case (bus.pc_src)
      3'b000: cand = seq;
      3'b001: cand = bus.branch_taken
                   ? {k, bus.branch_target[KB-1:0]}
                   : seq;
      3'b010: cand = {k, {(WIDTH-27){1'b0}},
                      bus.jump_target};
      3'b011: cand = {bus.jr_target[KB] & k,
                      bus.jr_target[KB-1:0]};
      3'b100: cand = ILLOP_VEC;
      default: cand = XADR_VEC;
    endcase
  end

  // PC / redirect buffer update, exception first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_VEC;
      pend_q <= 1'b0;
      buf_q  <= '0;
    end else if (exc) begin
      pc_q   <= cand;
      pend_q <= 1'b0;
    end else if (bus.stall) begin
      if (redir) begin
        buf_q  <= cand;
        pend_q <= 1'b1;
      end
    end else if (redir) begin
      pc_q   <= cand;
      pend_q <= 1'b0;
    end else if (pend_q) begin
      pc_q   <= buf_q;
      pend_q <= 1'b0;
    end else begin
      pc_q <= seq;
    end
  end
endmodule

// File: tb/tb_pc_unit_stall.sv
// Scoreboard bench for pc_unit_stall: random and
// directed stimulus against a spec-level model.
module tb_pc_unit_stall;
  localparam logic [31:0] MSB = 32'h80000000;
  localparam logic [31:0] LOW = 32'h7FFFFFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp;
    logic        pend;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  logic [31:0] m_pc = MSB;
  logic [31:0] m_buf = '0;
  logic        m_pend = 1'b0;

  pc_unit_stall_if #(.WIDTH(32)) bus ();

  pc_unit_stall dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] nxt_seq(
    input logic [31:0] p);
    return (p & MSB) | ((p + 32'd4) & LOW);
  endfunction

  function automatic logic [31:0] target(
    input logic [31:0] p, input logic [2:0] s,
    input logic tk, input logic [31:0] bt,
    input logic [25:0] jt, input logic [31:0] jr);
    if (s == 3'd0) return nxt_seq(p);
    if (s == 3'd1)
      return tk ? ((p & MSB) | (bt & LOW))
                : nxt_seq(p);
    if (s == 3'd2) return (p & MSB) | {6'd0, jt};
    if (s == 3'd3)
      return (jr & p & MSB) | (jr & LOW);
    if (s == 3'd4) return 32'h80000004;
    return 32'h80000008;
  endfunction

  // One clock of stimulus: drive, advance model, queue
  task automatic step(input logic rn,
                      input logic st,
                      input logic [2:0] s,
                      input logic tk,
                      input logic [31:0] bt,
                      input logic [25:0] jt,
                      input logic [31:0] jr);
    logic [31:0] c;
    logic        rd;
    exp_t        e;
    @(negedge clk);
    reset = rn;
    bus.stall = st;
    bus.pc_src = s;
    bus.branch_taken = tk;
    bus.branch_target = bt;
    bus.jump_target = jt;
    bus.jr_target = jr;
    c = target(m_pc, s, tk, bt, jt, jr);
    rd = (s == 3'd2) || (s == 3'd3)
      || (s == 3'd1 && tk);
    if (!rn) begin
      m_pc = MSB;
      m_pend = 1'b0;
      m_buf = '0;
    end else if (s >= 3'd4) begin
      m_pc = c;
      m_pend = 1'b0;
    end else if (st && rd) begin
      m_buf = c;
      m_pend = 1'b1;
    end else if (st) begin
      m_pc = m_pc;
    end else if (rd) begin
      m_pc = c;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_buf;
      m_pend = 1'b0;
    end else begin
      m_pc = nxt_seq(m_pc);
    end
    e.pc = m_pc;
    e.pcp = nxt_seq(m_pc);
    e.pend = m_pend;
    q.push_back(e);
  endtask

  task automatic go(input logic [2:0] s);
    step(1, 0, s, 0, 0, 0, 0);
  endtask

  task automatic jr_to(input logic [31:0] t);
    step(1, 0, 3'd3, 0, 0, 0, t);
  endtask

  task automatic spot(input string nm,
                      input logic [31:0] pc,
                      input logic pend);
    @(posedge clk);
    #2;
    chk({nm, "_pc"}, bus.pc, pc);
    chk({nm, "_pend"}, {31'd0, bus.redirect_pend},
        {31'd0, pend});
  endtask

  // Monitor: compare DUT against queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_pc", bus.pc, e.pc);
        chk("sb_pc_plus", bus.pc_plus, e.pcp);
        chk("sb_pend", {31'd0, bus.redirect_pend},
            {31'd0, e.pend});
      end
    end
  end

  initial begin
    int budget;
    logic [2:0] s;
    bus.stall = 0;
    bus.pc_src = 0;
    bus.branch_taken = 0;
    bus.branch_target = 0;
    bus.jump_target = 0;
    bus.jr_target = 0;
    #12;
    chk("reset_pc", bus.pc, MSB);
    chk("reset_pend", {31'd0, bus.redirect_pend},
        32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    go(0);
    go(0);
    go(0);
    // T1: async reset mid-run then release
    @(negedge clk);
    reset = 0;
    #1;
    chk("t1_async_pc", bus.pc, MSB);
    q.push_back('{MSB, 32'h80000004, 1'b0});
    m_pc = MSB;
    m_pend = 0;
    m_buf = 0;
    go(0);
    spot("t1_rel", 32'h80000004, 0);
    // T2: low-bit wrap keeps K
    jr_to(32'h7FFFFFFC);
    go(0);
    spot("t2_user_wrap", 32'h00000000, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    jr_to(32'hFFFFFFFC);
    go(0);
    spot("t2_kern_wrap", 32'h80000000, 0);
    // T3: jump buffered across a 3-cycle stall
    go(0);
    step(1, 1, 3'd2, 0, 0, 26'h0000100, 0);
    step(1, 1, 3'd2, 0, 0, 26'h0000100, 0);
    step(1, 1, 3'd2, 0, 0, 26'h0000100, 0);
    spot("t3_frozen", 32'h80000004, 1);
    go(0);
    go(0);
    // T4: exception beats stall and pending
    step(1, 1, 3'd1, 1, 32'h80000200, 0, 0);
    step(1, 1, 3'd5, 0, 0, 0, 0);
    spot("t4_exc", 32'h80000008, 0);
    go(0);
    // T5: JR kernel protection
    jr_to(32'h00400000);
    jr_to(32'h80001000);
    spot("t5_user", 32'h00001000, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    jr_to(32'h80000100);
    jr_to(32'h00400010);
    spot("t5_kern", 32'h00400010, 0);
    // T6: live branch beats buffered jump
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3'd2, 0, 0, 26'h55, 0);
    step(1, 0, 3'd1, 1, 32'h80000040, 0, 0);
    spot("t6_live", 32'h80000040, 0);
    go(0);
    spot("t6_drop", 32'h80000044, 0);
    // Random traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      s = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && s >= 3'd4)
        s = 3'($urandom_range(0, 3));
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) < 4),
           s, 1'($urandom),
           $urandom, 26'($urandom), $urandom);
    end
    go(0);
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      #3;
      budget++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left, need 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
